muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add (MUL) or restoring
// shift-subtract (DIV) step per cycle, then a sign-fixup cycle before HI/LO write.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_con_Start,
    input  logic [2:0]       i_con_Op,
    input  logic [WIDTH-1:0] i_data_A,
    input  logic [WIDTH-1:0] i_data_B,
    input  logic             i_con_Flush,
    output logic [WIDTH-1:0] o_data_Hi,
    output logic [WIDTH-1:0] o_data_Lo,
    output logic             o_con_Busy,
    output logic             o_con_Done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_is_div;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic               w_last;

    // Signed ops iterate on magnitudes; signs are reapplied in FIX.
    assign w_signed = (i_con_Op == OP_MULT) || (i_con_Op == OP_DIV);
    assign w_a_neg  = w_signed & i_data_A[WIDTH-1];
    assign w_b_neg  = w_signed & i_data_B[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~i_data_A + 1'b1) : i_data_A;
    assign w_b_mag  = w_b_neg ? (~i_data_B + 1'b1) : i_data_B;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ok    = ~w_div_diff[WIDTH];
    assign w_div_next  = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ok};

    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_acc[WIDTH-1:0];
    assign w_rem  = r_acc[2*WIDTH-1:WIDTH];

    // Divide by zero leaves the remainder equal to |dividend|, so only LO needs forcing.
    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            w_fix_hi = r_neg_r ? (~w_rem + 1'b1) : w_rem;
            w_fix_lo = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? (~w_quo + 1'b1) : w_quo);
        end
    end

    assign w_last = (r_cnt == CW'(WIDTH-1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_con_Start && !i_con_Flush) begin
                        case (i_con_Op)
                            OP_MULT, OP_MULTU: begin
                                r_state  <= S_MUL;
                                r_cnt    <= '0;
                                r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
                                r_opb    <= w_a_mag;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= 1'b0;
                                r_dz     <= 1'b0;
                                r_is_div <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_state  <= S_DIV;
                                r_cnt    <= '0;
                                r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                                r_opb    <= w_b_mag;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_dz     <= (i_data_B == '0);
                                r_is_div <= 1'b1;
                            end
                            OP_MTHI: begin
                                r_hi   <= i_data_A;
                                r_done <= 1'b1;
                            end
                            OP_MTLO: begin
                                r_lo   <= i_data_A;
                                r_done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (i_con_Flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last)
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!i_con_Flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_data_Hi  = r_hi;
    assign o_data_Lo  = r_lo;
    assign o_con_Busy = (r_state != S_IDLE);
    assign o_con_Done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, flush/ignore/reset corner cases.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_con_Start (start),
        .i_con_Op    (op),
        .i_data_A    (a),
        .i_data_B    (b),
        .i_con_Flush (flush),
        .o_data_Hi   (hi),
        .o_data_Lo   (lo),
        .o_con_Busy  (busy),
        .o_con_Done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Drive Start for exactly one rising edge; returns at the negedge after it.
    task automatic start_op(input logic [2:0] o, input logic [31:0] da, input logic [31:0] db,
                            input logic fl);
        @(negedge clk);
        start = 1'b1; op = o; a = da; b = db; flush = fl;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; a = 32'h5A5A_5A5A; b = 32'hC3C3_C3C3;
    endtask

    // Wait (bounded) for Done, counting Busy cycles and watching HI/LO stay frozen.
    task automatic wait_done(output int cycles, output logic stable, output logic got);
        logic [31:0] snap_hi = hi;
        logic [31:0] snap_lo = lo;
        cycles = 0;
        stable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (done) break;
            if (busy) cycles++;
            if (hi !== snap_hi || lo !== snap_lo) stable = 1'b0;
            @(negedge clk);
        end
        got = done;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] da,
                          input logic [31:0] db, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   cyc;
        logic stb;
        logic got;
        start_op(o, da, db, 1'b0);
        wait_done(cyc, stb, got);
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(cyc), 32'd33);
        check({tag, "_hilo_frozen"}, 32'(stb), 32'd1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        $display("[TB] %s A=%08h B=%08h -> HI=%08h LO=%08h busy_cycles=%0d", tag, da, db, hi, lo, cyc);
    endtask

    // Watch for any Done pulse over n cycles.
    task automatic no_done(input string tag, input int n);
        logic seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int   cyc;
        logic stb;
        logic got;

        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_neg1xneg1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
        run_op("div_neg7d2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dneg2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
        run_op("divu_100d0", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run_op("div_neg5d0", 3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // Overflow case with a Start (MTHI) pulsed at the fifth Busy cycle.
        start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, stb, got);
        check("div_ovf_done", 32'(got), 32'd1);
        check("div_ovf_busy_remaining", 32'(cyc), 32'd28);
        check("div_ovf_hi", hi, 32'h0);
        check("div_ovf_lo", lo, 32'h8000_0000);
        $display("[TB] div_ovf 80000000/FFFFFFFF -> HI=%08h LO=%08h", hi, lo);
        no_done("div_ovf_no_second_done", 40);
        check("div_ovf_hi_after", hi, 32'h0);

        start_op(3'd4, 32'h0000_1234, 32'h0, 1'b0);
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo", lo, 32'h8000_0000);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_done", 32'(done), 32'd1);
        @(negedge clk);
        check("mthi_done_one_cycle", 32'(done), 32'd0);
        $display("[TB] mthi A=00001234 -> HI=%08h", hi);

        // DIVU 10/3 flushed while the counter holds 10.
        start_op(3'd3, 32'd10, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_low", 32'(busy), 32'd0);
        check("flush_hi", hi, 32'h0000_1234);
        check("flush_lo", lo, 32'h8000_0000);
        no_done("flush_no_done", 40);
        $display("[TB] divu 10/3 flushed -> HI=%08h LO=%08h", hi, lo);
        run_op("multu_after_flush", 3'd1, 32'd3, 32'd5, 32'h0, 32'd15);

        // Flush arriving while in FIX suppresses the write.
        start_op(3'd1, 32'd2, 32'd3, 1'b0);
        repeat (32) @(negedge clk);
        check("fixflush_busy_in_fix", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fixflush_busy", 32'(busy), 32'd0);
        check("fixflush_done", 32'(done), 32'd0);
        check("fixflush_hi", hi, 32'h0);
        check("fixflush_lo", lo, 32'd15);
        no_done("fixflush_no_done", 5);
        $display("[TB] multu 2*3 flushed in fix -> HI=%08h LO=%08h", hi, lo);

        start_op(3'd5, 32'h0000_0077, 32'h0, 1'b1);
        check("flush_start_lo", lo, 32'd15);
        check("flush_start_done", 32'(done), 32'd0);
        check("flush_start_busy", 32'(busy), 32'd0);
        $display("[TB] mtlo with flush -> LO=%08h", lo);

        start_op(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("op6_busy", 32'(busy), 32'd0);
        check("op6_done", 32'(done), 32'd0);
        check("op6_hi", hi, 32'h0);
        check("op6_lo", lo, 32'd15);
        $display("[TB] op6 -> HI=%08h LO=%08h", hi, lo);

        // Asynchronous reset asserted between clock edges mid-MULT.
        start_op(3'd0, 32'd5, 32'd6, 1'b0);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_hi", hi, 32'h0);
        check("areset_lo", lo, 32'h0);
        check("areset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_op(3'd5, 32'h0000_00A5, 32'h0, 1'b0);
        check("post_reset_mtlo_lo", lo, 32'h0000_00A5);
        check("post_reset_mtlo_done", 32'(done), 32'd1);
        $display("[TB] reset mid-mult then mtlo A5 -> HI=%08h LO=%08h", hi, lo);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
